// File: rtl/qam16_modulator_pkg.sv
// Shared types, widths and helpers for the QAM-16 modulator slice.
package qam16_modulator_pkg;

  localparam int QAM_SINE_W   = 10;  // signed sine/cosine sample width, peak +/-511
  localparam int QAM_PHASE_W  = 16;  // NCO phase accumulator width
  localparam int QAM_ADDR_W   = 8;   // sine table address width (phase[15:8])
  localparam int QAM_SAMPLE_W = 13;  // passband sample width, |sample| <= 3066

  // One I or Q amplitude level: -3, -1, +1 or +3.
  typedef logic signed [2:0] QAM_LEVEL;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } qamState_t;

  // Gray-coded two-bit field to amplitude level; adjacent levels differ in one bit.
  function automatic QAM_LEVEL grayLevel(input logic [1:0] bits);
    case (bits)
      2'b00:   grayLevel = 3'sb101;  // -3
      2'b01:   grayLevel = 3'sb111;  // -1
      2'b11:   grayLevel = 3'sb001;  // +1
      2'b10:   grayLevel = 3'sb011;  // +3
      default: grayLevel = 3'sb000;
    endcase
  endfunction

endpackage

// File: rtl/qam16_modulator_sine_lut.sv
// qam_sine_lut: 256-entry sine ROM, entry k = round(511*sin(2*pi*k/256)),
// built from a 65-entry quarter wave. Two independent registered read ports.
module qam_sine_lut
  import qam16_modulator_pkg::*;
(
  input  logic                         ipClk,
  input  logic                         ipReset,
  input  logic [QAM_ADDR_W-1:0]        ipSinAddr,
  input  logic [QAM_ADDR_W-1:0]        ipCosAddr,
  output logic signed [QAM_SINE_W-1:0] opSin,
  output logic signed [QAM_SINE_W-1:0] opCos
);

  // First quadrant magnitude, index 0..64 covers 0..90 degrees inclusive.
  function automatic logic [8:0] quarterVal(input logic [6:0] idx);
    case (idx)
      7'd0:  quarterVal = 9'd0;   7'd1:  quarterVal = 9'd13;  7'd2:  quarterVal = 9'd25;
      7'd3:  quarterVal = 9'd38;  7'd4:  quarterVal = 9'd50;  7'd5:  quarterVal = 9'd63;
      7'd6:  quarterVal = 9'd75;  7'd7:  quarterVal = 9'd87;  7'd8:  quarterVal = 9'd100;
      7'd9:  quarterVal = 9'd112; 7'd10: quarterVal = 9'd124; 7'd11: quarterVal = 9'd136;
      7'd12: quarterVal = 9'd148; 7'd13: quarterVal = 9'd160; 7'd14: quarterVal = 9'd172;
      7'd15: quarterVal = 9'd184; 7'd16: quarterVal = 9'd196; 7'd17: quarterVal = 9'd207;
      7'd18: quarterVal = 9'd218; 7'd19: quarterVal = 9'd230; 7'd20: quarterVal = 9'd241;
      7'd21: quarterVal = 9'd252; 7'd22: quarterVal = 9'd263; 7'd23: quarterVal = 9'd273;
      7'd24: quarterVal = 9'd284; 7'd25: quarterVal = 9'd294; 7'd26: quarterVal = 9'd304;
      7'd27: quarterVal = 9'd314; 7'd28: quarterVal = 9'd324; 7'd29: quarterVal = 9'd334;
      7'd30: quarterVal = 9'd343; 7'd31: quarterVal = 9'd352; 7'd32: quarterVal = 9'd361;
      7'd33: quarterVal = 9'd370; 7'd34: quarterVal = 9'd379; 7'd35: quarterVal = 9'd387;
      7'd36: quarterVal = 9'd395; 7'd37: quarterVal = 9'd403; 7'd38: quarterVal = 9'd410;
      7'd39: quarterVal = 9'd418; 7'd40: quarterVal = 9'd425; 7'd41: quarterVal = 9'd432;
      7'd42: quarterVal = 9'd438; 7'd43: quarterVal = 9'd445; 7'd44: quarterVal = 9'd451;
      7'd45: quarterVal = 9'd456; 7'd46: quarterVal = 9'd462; 7'd47: quarterVal = 9'd467;
      7'd48: quarterVal = 9'd472; 7'd49: quarterVal = 9'd477; 7'd50: quarterVal = 9'd481;
      7'd51: quarterVal = 9'd485; 7'd52: quarterVal = 9'd489; 7'd53: quarterVal = 9'd492;
      7'd54: quarterVal = 9'd496; 7'd55: quarterVal = 9'd499; 7'd56: quarterVal = 9'd501;
      7'd57: quarterVal = 9'd503; 7'd58: quarterVal = 9'd505; 7'd59: quarterVal = 9'd507;
      7'd60: quarterVal = 9'd509; 7'd61: quarterVal = 9'd510; 7'd62: quarterVal = 9'd510;
      7'd63: quarterVal = 9'd511; 7'd64: quarterVal = 9'd511;
      default: quarterVal = 9'd0;
    endcase
  endfunction

  // Full-wave value: addr[6] mirrors within the half, addr[7] negates.
  function automatic logic signed [QAM_SINE_W-1:0] lutVal(input logic [QAM_ADDR_W-1:0] addr);
    logic [6:0]            idx;
    logic [QAM_SINE_W-1:0] mag;
    if (addr[6]) begin
      idx = 7'd64 - {1'b0, addr[5:0]};
    end else begin
      idx = {1'b0, addr[5:0]};
    end
    mag = {1'b0, quarterVal(idx)};
    if (addr[7]) begin
      lutVal = -$signed(mag);
    end else begin
      lutVal = $signed(mag);
    end
  endfunction

  // Registered read of both ports every cycle; one cycle of latency.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opSin <= '0;
      opCos <= '0;
    end else begin
      opSin <= lutVal(ipSinAddr);
      opCos <= lutVal(ipCosAddr);
    end
  end

endmodule

// File: rtl/qam16_modulator.sv
// qam16_modulator: Gray-mapped QAM-16 symbols mixed onto an NCO carrier,
// one signed passband sample every SAMPLE_DIV clocks, three-stage pipeline.
// Build option QAM_IDLE_CARRIER_EN: when defined, IDLE emits a plain cosine
// carrier (I=+1, Q=0); when undefined IDLE emits zero samples.
module qam16_modulator
  import qam16_modulator_pkg::*;
#(
  parameter int                     SAMPLE_DIV = 50,
  parameter logic [QAM_PHASE_W-1:0] PHASE_INC  = 16'd4096,
  parameter int                     HOLD_TICKS = 128
) (
  input  logic                           ipClk,
  input  logic                           ipReset,
  input  logic [3:0]                     ipSymbol,
  input  logic                           ipSymbolValid,
  output logic signed [QAM_SAMPLE_W-1:0] opSample,
  output logic                           opSampleValid,
  output logic                           opActive,
  output logic                           opUnderrun
);

  localparam int                DIV_W     = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam int                HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

`ifdef QAM_IDLE_CARRIER_EN
  localparam QAM_LEVEL IDLE_LEVEL_I = 3'sb001;
`else
  localparam QAM_LEVEL IDLE_LEVEL_I = 3'sb000;
`endif
  localparam QAM_LEVEL IDLE_LEVEL_Q = 3'sb000;

  logic [DIV_W-1:0]              divCnt_r;
  logic                          tick_s;
  logic [QAM_PHASE_W-1:0]        phase_r;
  logic [3:0]                    symbol_r;
  qamState_t                     state_r, stateNext_s;
  logic [HOLD_W-1:0]             holdCnt_r, holdNext_s;
  logic                          underrunNext_s;
  QAM_LEVEL                      levI_s, levQ_s;
  logic [QAM_ADDR_W-1:0]         sinAddr_s, cosAddr_s;
  logic signed [QAM_SINE_W-1:0]  lutSin_s, lutCos_s;
  logic                          valid1_r, valid2_r;
  QAM_LEVEL                      levI1_r, levQ1_r;
  logic signed [QAM_SAMPLE_W-1:0] extI_s, extQ_s, extSin_s, extCos_s;
  logic signed [QAM_SAMPLE_W-1:0] prodI_r, prodQ_r;

  assign tick_s    = (divCnt_r == DIV_LAST);
  assign sinAddr_s = phase_r[QAM_PHASE_W-1 -: QAM_ADDR_W];
  assign cosAddr_s = sinAddr_s + 8'd64;

  // Sample-rate divider: counts 0..SAMPLE_DIV-1, tick on the last count.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      divCnt_r <= '0;
    end else if (tick_s) begin
      divCnt_r <= '0;
    end else begin
      divCnt_r <= divCnt_r + DIV_W'(1);
    end
  end

  // NCO phase advances once per tick; the tick itself reads the old phase.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      phase_r <= '0;
    end else if (tick_s) begin
      phase_r <= phase_r + PHASE_INC;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Current symbol: every strobe is taken, the latest one wins.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      symbol_r <= 4'd0;
    end else if (ipSymbolValid) begin
      symbol_r <= ipSymbol;
    end else begin
      symbol_r <= symbol_r;
    end
  end

  // State, hold counter and registered status outputs.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_r    <= IDLE;
      holdCnt_r  <= '0;
      opActive   <= 1'b0;
      opUnderrun <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      holdCnt_r  <= holdNext_s;
      opActive   <= (stateNext_s == ACTIVE);
      opUnderrun <= underrunNext_s;
    end
  end

  // Next state: a strobe always wins over the hold-counter increment.
  always_comb begin
    stateNext_s    = state_r;
    holdNext_s     = holdCnt_r;
    underrunNext_s = 1'b0;
    if (ipSymbolValid) begin
      stateNext_s = ACTIVE;
      holdNext_s  = '0;
    end else if ((state_r == ACTIVE) && tick_s) begin
      if (holdCnt_r == HOLD_LAST) begin
        stateNext_s    = IDLE;
        holdNext_s     = '0;
        underrunNext_s = 1'b1;
      end else begin
        holdNext_s = holdCnt_r + HOLD_W'(1);
      end
    end else begin
      holdNext_s = holdCnt_r;
    end
  end

  // Amplitude levels in use for a tick in the current state.
  always_comb begin
    levI_s = 3'sb000;
    levQ_s = 3'sb000;
    case (state_r)
      ACTIVE: begin
        levI_s = grayLevel(symbol_r[1:0]);
        levQ_s = grayLevel(symbol_r[3:2]);
      end
      IDLE: begin
        levI_s = IDLE_LEVEL_I;
        levQ_s = IDLE_LEVEL_Q;
      end
      default: begin
        levI_s = 3'sb000;
        levQ_s = 3'sb000;
      end
    endcase
  end

  qam_sine_lut uSineLut (
    .ipClk     (ipClk),
    .ipReset   (ipReset),
    .ipSinAddr (sinAddr_s),
    .ipCosAddr (cosAddr_s),
    .opSin     (lutSin_s),
    .opCos     (lutCos_s)
  );

  // Stage 1: levels captured alongside the registered table lookup.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      valid1_r <= 1'b0;
      levI1_r  <= 3'sb000;
      levQ1_r  <= 3'sb000;
    end else if (tick_s) begin
      valid1_r <= 1'b1;
      levI1_r  <= levI_s;
      levQ1_r  <= levQ_s;
    end else begin
      valid1_r <= 1'b0;
      levI1_r  <= levI1_r;
      levQ1_r  <= levQ1_r;
    end
  end

  assign extI_s   = {{(QAM_SAMPLE_W-3){levI1_r[2]}}, levI1_r};
  assign extQ_s   = {{(QAM_SAMPLE_W-3){levQ1_r[2]}}, levQ1_r};
  assign extCos_s = {{(QAM_SAMPLE_W-QAM_SINE_W){lutCos_s[QAM_SINE_W-1]}}, lutCos_s};
  assign extSin_s = {{(QAM_SAMPLE_W-QAM_SINE_W){lutSin_s[QAM_SINE_W-1]}}, lutSin_s};

  // Stage 2: I*cos and Q*sin; each product is at most 1533 in magnitude.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      valid2_r <= 1'b0;
      prodI_r  <= '0;
      prodQ_r  <= '0;
    end else if (valid1_r) begin
      valid2_r <= 1'b1;
      prodI_r  <= extI_s * extCos_s;
      prodQ_r  <= extQ_s * extSin_s;
    end else begin
      valid2_r <= 1'b0;
      prodI_r  <= prodI_r;
      prodQ_r  <= prodQ_r;
    end
  end

  // Stage 3: passband sample I*cos - Q*sin, fits 13 bits without saturation.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opSampleValid <= 1'b0;
      opSample      <= '0;
    end else if (valid2_r) begin
      opSampleValid <= 1'b1;
      opSample      <= prodI_r - prodQ_r;
    end else begin
      opSampleValid <= 1'b0;
      opSample      <= opSample;
    end
  end

endmodule

// File: tb/tb_qam16_modulator.sv
// Scoreboard bench for qam16_modulator: stimulus pushes expected samples
// (indexed by sample number since reset), a monitor pops and compares.
module tb_qam16_modulator;

  logic              ipClk = 1'b0;
  logic              ipReset;
  logic [3:0]        ipSymbol;
  logic              ipSymbolValid;
  logic signed [12:0] opSample;
  logic              opSampleValid;
  logic              opActive;
  logic              opUnderrun;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int sampleIdx = 0;
  int firstValidEdge = -1;
  int underrunCount = 0;
  int underrunHighCycles = 0;
  int lastUnderrunEdge = -1;

  typedef struct { int idx; int val; } exp_t;
  exp_t expQ[$];

  qam16_modulator #(.SAMPLE_DIV(50), .PHASE_INC(16'd4096), .HOLD_TICKS(128)) dut (
    .ipClk         (ipClk),
    .ipReset       (ipReset),
    .ipSymbol      (ipSymbol),
    .ipSymbolValid (ipSymbolValid),
    .opSample      (opSample),
    .opSampleValid (opSampleValid),
    .opActive      (opActive),
    .opUnderrun    (opUnderrun)
  );

  always #5 ipClk = ~ipClk;

  // Rising edges since the last reset release.
  always @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) edges <= 0;
    else          edges <= edges + 1;
  end

  // Table values at the 16 phases visited with PHASE_INC=4096 (addr = 16*j).
  function automatic int sin16(input int j);
    case (j)
      0: return 0;     1: return 196;   2: return 361;   3: return 472;
      4: return 511;   5: return 472;   6: return 361;   7: return 196;
      8: return 0;     9: return -196;  10: return -361; 11: return -472;
      12: return -511; 13: return -472; 14: return -361; 15: return -196;
      default: return 0;
    endcase
  endfunction

  function automatic int cos16(input int j);
    return sin16((j + 4) % 16);
  endfunction

  function automatic int idleI();
`ifdef QAM_IDLE_CARRIER_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic int model(input int n, input int i, input int q);
    return i * cos16(n % 16) - q * sin16(n % 16);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expectSample(input int n, input int i, input int q);
    expQ.push_back('{n, model(n, i, q)});
  endtask

  task automatic waitEdge(input int e);
    while (edges < e) @(negedge ipClk);
  endtask

  // Strobe a symbol so that it is latched on rising edge e.
  task automatic strobeAt(input int e, input logic [3:0] s);
    waitEdge(e - 1);
    ipSymbol      = s;
    ipSymbolValid = 1'b1;
    @(negedge ipClk);
    ipSymbolValid = 1'b0;
  endtask

  task automatic doReset(input string tag);
    ipReset       = 1'b0;
    ipSymbolValid = 1'b0;
    ipSymbol      = 4'd0;
    repeat (5) @(negedge ipClk);
    check({tag, "_sample"},   int'(opSample), 0);
    check({tag, "_valid"},    int'(opSampleValid), 0);
    check({tag, "_active"},   int'(opActive), 0);
    check({tag, "_underrun"}, int'(opUnderrun), 0);
    ipReset = 1'b1;
  endtask

  // Monitor: pop and compare on every presented sample; track underrun pulses.
  always @(negedge ipClk) begin
    if (!ipReset) begin
      sampleIdx      = 0;
      firstValidEdge = -1;
    end else begin
      if (opUnderrun) begin
        underrunHighCycles++;
        if (lastUnderrunEdge != edges - 1) underrunCount++;
        lastUnderrunEdge = edges;
      end
      if (opSampleValid) begin
        if (firstValidEdge < 0) firstValidEdge = edges;
        while (expQ.size() > 0 && expQ[0].idx < sampleIdx) begin
          checks++;
          failures++;
          $display("FAIL missed_sample_%0d actual=absent required=%0d", expQ[0].idx, expQ[0].val);
          void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].idx == sampleIdx) begin
          check($sformatf("sample_%0d", sampleIdx), int'(opSample), expQ[0].val);
          void'(expQ.pop_front());
        end
        sampleIdx++;
      end
    end
  end

  // Watchdog against a stalled run.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    ipReset       = 1'b0;
    ipSymbol      = 4'd0;
    ipSymbolValid = 1'b0;
    doReset("reset1");

    // IDLE sample at phase 0; tick at edge 49 -> sample after edge 52.
    expectSample(0, idleI(), 0);
    strobeAt(60, 4'b1010);                       // I=+3, Q=+3 from tick 1
    check("active_after_strobe", int'(opActive), 1);
    check("first_valid_edge", firstValidEdge, 52);
    expectSample(1, 3, 3);                       // 828
    expectSample(4, 3, 3);                       // addr 64: -1533
    expectSample(16, 3, 3);                      // phase 0: +1533

    strobeAt(860, 4'b0000);                      // I=-3, Q=-3 from tick 17
    expectSample(17, -3, -3);                    // -828
    expectSample(20, -3, -3);                    // +1533
    expectSample(32, -3, -3);                    // -1533

    strobeAt(1660, 4'b0111);                     // I=+1, Q=-1 from tick 33
    expectSample(33, 1, -1);                     // 668
    expectSample(48, 1, -1);                     // 511
    expectSample(50, 1, -1);                     // coincident tick keeps old symbol: 722

    strobeAt(2550, 4'b1010);                     // latched on tick 50's own edge
    expectSample(51, 3, 3);                      // new symbol from next tick: -828
    expectSample(177, 3, 3);                     // still ACTIVE: 828
    expectSample(178, 3, 3);                     // timeout tick still ACTIVE: 0
    expectSample(179, idleI(), 0);               // IDLE from here
    expectSample(181, idleI(), 0);

    // Hold counter restarted at 0 on edge 2550: 128th tick after is tick 178.
    waitEdge(8960);
    check("underrun_edge", lastUnderrunEdge, 8950);
    check("underrun_count", underrunCount, 1);
    check("active_after_timeout", int'(opActive), 0);

    // Strobes every 113 ticks keep ACTIVE without any underrun.
    strobeAt(9260, 4'b0000);
    expectSample(188, -3, -3);                   // -1533
    strobeAt(14910, 4'b1010);
    expectSample(300, 3, 3);                     // 1533
    strobeAt(20560, 4'b0111);
    expectSample(416, 1, -1);                    // 511
    waitEdge(26000);
    check("underrun_count_steady", underrunCount, 1);
    check("active_steady", int'(opActive), 1);

    // Reset one cycle after tick 530 (latched on edge 26550): its sample is lost.
    waitEdge(26551);
    check("samples_before_reset", sampleIdx, 530);
    check("queue_drained_before_reset", expQ.size(), 0);
    doReset("reset2");

    expectSample(0, idleI(), 0);
    strobeAt(60, 4'b1010);
    expectSample(1, 3, 3);
    expectSample(4, 3, 3);
    waitEdge(300);
    check("first_valid_edge_after_reset", firstValidEdge, 52);
    check("queue_drained_end", expQ.size(), 0);
    check("underrun_total", underrunCount, 1);
    check("underrun_pulse_cycles", underrunHighCycles, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qam16_modulator.md
# qam16_modulator

Baseband-to-passband QAM-16 modulator sitting directly downstream of the FIFO streamer in the modulator path. Consumes the 4-bit symbol strobe (`opQAMBlock` / `opQAMBlockValid`), maps each symbol onto Gray-coded I/Q levels and mixes them onto a digital carrier from a phase-accumulator NCO. Emits one signed passband sample per sample tick, continuously, towards the DAC interface.

## Interface
- `SAMPLE_DIV`, 50: clock cycles per output sample. Must be 4 or more.
- `PHASE_INC`, 16'd4096: NCO phase step per sample tick. The default gives a carrier of fs/16.
- `HOLD_TICKS`, 128: sample ticks with no new symbol before dropping to IDLE.
- `ipClk` input, 1 bit: system clock.
- `ipReset` input, 1 bit: reset, asynchronous, active-low.
- `ipSymbol` input, 4 bits: QAM symbol. Bits [1:0] drive I; bits [3:2] drive Q.
- `ipSymbolValid` input, 1 bit: single-cycle strobe qualifying `ipSymbol`.
- `opSample` output, 13 bits signed: passband sample.
- `opSampleValid` output, 1 bit: one-cycle pulse per sample.
- `opActive` output, 1 bit: high in ACTIVE state.
- `opUnderrun` output, 1 bit: one-cycle pulse on the ACTIVE→IDLE timeout.

## Operation
- **Level map (Gray)**, applied identically to I and Q:
  - 00 → -3
  - 01 → -1
  - 11 → +1
  - 10 → +3
- **Symbol capture**
  - On any cycle with `ipSymbolValid`=1, `ipSymbol` is latched into the current-symbol register.
  - Latching forces ACTIVE and clears the hold counter.
  - No back-pressure: every strobe is accepted, and the last one wins.
- **Sample tick**
  - Divider counts 0..SAMPLE_DIV-1; a tick fires on the cycle it equals SAMPLE_DIV-1, then it wraps to 0.
  - On every tick: phase += PHASE_INC (mod 2^16, wraps silently).
  - Table address = phase[15:8]. `sin` = table[addr]; `cos` = table[addr+64 mod 256].
- **Sample arithmetic**
  - opSample = I·cos − Q·sin, where sin/cos are 10-bit signed, peak ±511.
  - Magnitude ≤ 3066, so 13 bits signed never overflows. No saturation logic is required.
- **State machine**
  - IDLE → ACTIVE on `ipSymbolValid`.
  - ACTIVE → IDLE when the hold counter reaches HOLD_TICKS. The counter increments per tick and is cleared by each strobe.
  - On that transition `opUnderrun` pulses for one cycle.
  - IDLE sample content is set by Configuration.
- **Simultaneous strobe and tick**
  - The tick is computed with the symbol held before the strobe.
  - The new symbol applies from the following tick.
  - The hold counter ends at 0, because the strobe wins over the increment.
- **Continuous output**: samples are produced in IDLE as well, so `opSampleValid` cadence never stops after reset.
- **Reset** (async assert at any time, including mid-pipeline)
  - `opSample`=0, `opSampleValid`=0, `opActive`=0, `opUnderrun`=0.
  - Phase, divider, hold counter and symbol all 0; state IDLE.
  - In-flight pipeline contents are discarded.

## Timing
- **Pipeline from tick cycle T**
  - Stage 1 (T+1): table lookup registered.
  - Stage 2 (T+2): products registered.
  - Stage 3 (T+3): difference registered, `opSampleValid`=1.
- **Latency**: 3 cycles from tick to sample.
- **Sample period**: exactly SAMPLE_DIV cycles.
- **Phase timing**: the first tick after reset uses phase 0; its phase update takes effect for the next tick.
- **Hold-out margin**: HOLD_TICKS·SAMPLE_DIV = 6400 cycles. This exceeds the streamer's slow-mode nibble spacing (~5670 cycles), so ACTIVE persists across both streamer modes.

## Configuration
- `QAM_IDLE_CARRIER_EN`
  - Defined: IDLE forces I=+1, Q=0, so IDLE outputs an unmodulated cos carrier for receiver carrier lock.
  - Undefined: IDLE forces I=0, Q=0, so `opSample`=0 in IDLE.
- ACTIVE behaviour is identical with or without the macro.

## Structure
- **Shared `Structures` package**
  - `QAM_LEVEL` typedef: 3-bit signed.
  - Gray level-map function.
  - `QAM_SINE_W`=10.
  - `QAM_PHASE_W`=16.
- **Sub-module `qam_sine_lut`**
  - 256-entry registered ROM, entry k = round(511·sin(2πk/256)).
  - Two read ports (sin and cos addresses), 1-cycle latency.

## Test plan
- **Reset**: hold `ipReset`=0 for 5 cycles, then release → all outputs 0. First `opSampleValid` at cycle 53 after release (tick at divider value 49, +3 pipeline latency). That sample is 0 without the macro, or +511 with `QAM_IDLE_CARRIER_EN`.
- **Symbol 4'b1010 (I=+3, Q=+3)** strobed before the first tick → first sample (phase 0) = +1533; fifth sample (addr 64) = −1533; `opActive`=1.
- **Symbol 4'b0000 (I=−3, Q=−3)** → phase-0 sample = −1533; addr-64 sample = +1533. **Symbol 4'b0111 (I=+1, Q=−1)** → phase-0 sample = +511.
- **Timeout**: one strobe, then none for 128 ticks → `opUnderrun` pulses exactly once, `opActive`=0, subsequent samples 0 (macro off). Strobes every 113 ticks → no underrun ever.
- **Strobe coincident with a tick** (divider=49): that tick uses the old symbol; the next sample uses the new one; the hold counter reads 0.
- **Reset mid-operation**: assert `ipReset` one cycle after a tick → no `opSampleValid` emerges from the flushed pipeline. After release, phase restarts at 0 and the first sample repeats the post-reset values.
